msd_dram_cmd_gen: RTL and testbench
===================================

Name: msd_dram_cmd_gen

Overview:
- Downstream stage of the memory-controller request queue.
- Pops one queued request at a time (2-bit operation, 36-bit address) and decodes the address into DDR5 bank-group, bank, row and column.
- Emits a timed DDR5 command sequence (two-cycle ACT, RD or WR, PRE) to the DIMM command interface.
- Enforces tRCD, tCL/tCWL, tBURST, tRAS, tWR and tRP with internal counters.

Parameters:
- T_RCD, 39, ACT0-to-CAS0 delay in clocks
- T_CL, 40, RD0-to-first-data in clocks
- T_CWL, 38, WR0-to-first-data in clocks
- T_BURST, 8, data burst length in clocks
- T_RAS, 76, ACT0-to-PRE minimum in clocks
- T_WR, 30, end-of-write-data-to-PRE in clocks
- T_RP, 39, PRE-to-next-ACT0 in clocks

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  queue head valid
- req_ready  out  1  block can accept a request
- req_oper  in  2  0=read, 1=write, 2=ifetch (handled as read), 3=reserved (handled as read)
- req_addr  in  36  physical address
- cmd_valid  out  1  a non-NOP command is on cmd_* this cycle
- cmd_code  out  3  0 NOP, 1 ACT0, 2 ACT1, 3 RD0, 4 RD1, 5 WR0, 6 WR1, 7 PRE
- cmd_bg  out  3  bank group
- cmd_ba  out  2  bank
- cmd_row  out  16  row address
- cmd_col  out  10  column address
- done  out  1  one-cycle pulse when the data burst of the current request completes
- busy  out  1  state is not IDLE

Behaviour:
- Address map:
  - row = addr[33:18]
  - col = {addr[17:12], addr[5:2]}
  - ba = addr[11:10]
  - bg = addr[9:7]
  - addr[6] (channel), addr[1:0] and addr[35:34] are ignored.
- Reset (async, any state): state=IDLE; cmd_valid=0, cmd_code=0, cmd_bg/ba/row/col=0, done=0, all counters 0.
- req_ready = (state==IDLE); combinational, so it reads 1 during reset. Requests are ignored while rst=1.
- Accept on the edge where req_valid && req_ready. The request is latched and not re-sampled until the next IDLE.
- Timing reference: the acceptance edge is cycle 0. All cmd_* and done outputs are registered.
- FSM states: IDLE, ACT0, ACT1, WAIT_RCD, CAS0, CAS1, WAIT_DATA, PRE, WAIT_RP.
- Command schedule:
  - ACT0 at cycle 1, ACT1 at cycle 2.
  - CAS0 (RD0 or WR0) at cycle 1+T_RCD; CAS1 on the following cycle.
  - Data end D:
    - read: CAS0+T_CL+T_BURST
    - write: CAS0+T_CWL+T_BURST
  - done pulses in cycle D.
  - PRE cycle = max(ACT0+T_RAS, D) for reads, max(ACT0+T_RAS, D+T_WR) for writes.
  - WAIT_RP lasts T_RP cycles after PRE; IDLE (req_ready=1) at PRE+T_RP.
- cmd_code=0 and cmd_valid=0 in every cycle where no command is issued.
- cmd_bg/ba/row/col hold the latched request fields throughout a sequence.
- A T_RAS counter starts at ACT0 and runs in parallel with the CAS and data waits.
- Counter widths must hold max(T_*)+T_BURST+T_WR without wrap.
- A new req_valid while busy is ignored; the request must stay at the queue head.
- done and PRE may land in the same cycle; both are emitted.
- Reset mid-sequence aborts immediately; no PRE is issued.

Optional Feature:
- Macro: MSD_OPEN_PAGE_EN
- Defined:
  - Open-page policy. Per-bank open-row table (32 entries: valid bit + 16-bit row), cleared on reset.
  - No PRE after data; return to IDLE at D (read) or D+T_WR (write).
  - Next request:
    - hit (same bank, valid, same row): skip ACT; CAS0 at cycle 1.
    - miss (different row in an open bank): PRE at cycle 1, then ACT0 at 1+T_RP, then the normal sequence.
    - bank not open: closed-page sequence without the final PRE.
  - T_RAS is tracked per bank from its last ACT0.
- Undefined: closed-page behaviour exactly as above; no table is built.

Test Plan:
- Read, addr=36'h0_0004_0680 (row=1, bg=5, ba=1, col=0) -> ACT0@1, ACT1@2, RD0@40, RD1@41, done@88, PRE@88, req_ready@127; cmd_bg=5, cmd_ba=1, cmd_row=1.
- Write, same address -> WR0@40, WR1@41, done@86, PRE@116 (tWR bound), req_ready@155.
- Ifetch (oper=2) -> identical sequence to read; RD codes, not WR.
- req_valid held high across two back-to-back reads -> second ACT0 at cycle 128; req_ready=0 during cycles 1..126.
- rst pulsed at cycle 50 of a read -> all outputs 0 the same cycle, no PRE issued, req_ready=1 after release.
- MSD_OPEN_PAGE_EN: read row 1, then read row 1 same bank -> second sequence has no ACT (RD0@1 after accept). Third read row 2 same bank -> PRE@1, ACT0@40.

Source files
------------

// File: rtl/msd_dram_cmd_gen.sv
// DDR5 command generator: pops one queued request, decodes the address and issues a timed
// ACT/CAS/PRE sequence. Define MSD_OPEN_PAGE_EN to build the open-page (per-bank row table) policy.
module msd_dram_cmd_gen #(
   parameter int unsigned T_RCD   = 39,
   parameter int unsigned T_CL    = 40,
   parameter int unsigned T_CWL   = 38,
   parameter int unsigned T_BURST = 8,
   parameter int unsigned T_RAS   = 76,
   parameter int unsigned T_WR    = 30,
   parameter int unsigned T_RP    = 39
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_oper,
   input  logic [35:0] req_addr,
   output logic        cmd_valid,
   output logic [2:0]  cmd_code,
   output logic [2:0]  cmd_bg,
   output logic [1:0]  cmd_ba,
   output logic [15:0] cmd_row,
   output logic [9:0]  cmd_col,
   output logic        done,
   output logic        busy
);
   localparam int unsigned T_M0   = (T_RCD > T_CL) ? T_RCD : T_CL;
   localparam int unsigned T_M1   = (T_M0 > T_CWL) ? T_M0 : T_CWL;
   localparam int unsigned T_M2   = (T_M1 > T_BURST) ? T_M1 : T_BURST;
   localparam int unsigned T_M3   = (T_M2 > T_RAS) ? T_M2 : T_RAS;
   localparam int unsigned T_M4   = (T_M3 > T_WR) ? T_M3 : T_WR;
   localparam int unsigned T_MAX  = (T_M4 > T_RP) ? T_M4 : T_RP;
   localparam int unsigned CNT_W  = $clog2(T_MAX + T_BURST + T_WR + 1);
   // Cycles from CAS1 to the last data cycle
   localparam int unsigned LAT_RD = T_CL + T_BURST - 1;
   localparam int unsigned LAT_WR = T_CWL + T_BURST - 1;

   localparam logic [2:0] CMD_NOP  = 3'd0;
   localparam logic [2:0] CMD_ACT0 = 3'd1;
   localparam logic [2:0] CMD_ACT1 = 3'd2;
   localparam logic [2:0] CMD_RD0  = 3'd3;
   localparam logic [2:0] CMD_RD1  = 3'd4;
   localparam logic [2:0] CMD_WR0  = 3'd5;
   localparam logic [2:0] CMD_WR1  = 3'd6;
   localparam logic [2:0] CMD_PRE  = 3'd7;

   typedef enum logic [3:0] {
      S_IDLE, S_ACT0, S_ACT1, S_WAIT_RCD, S_CAS0, S_CAS1, S_WAIT_DATA, S_PRE, S_WAIT_RP
   } state_t;

   state_t             state;
   logic               is_wr;
   logic [CNT_W-1:0]   wait_cnt;
   logic [CNT_W-1:0]   ras_cnt;
   logic [CNT_W-1:0]   dat_cnt;
   logic [CNT_W-1:0]   pre_cnt;

   // Address decode of the queue head
   logic [15:0] req_row;
   logic [9:0]  req_col;
   logic [1:0]  req_ba;
   logic [2:0]  req_bg;
   logic        req_wr;
   logic        addr_unused;

   assign req_row     = req_addr[33:18];
   assign req_col     = {req_addr[17:12], req_addr[5:2]};
   assign req_ba      = req_addr[11:10];
   assign req_bg      = req_addr[9:7];
   assign req_wr      = (req_oper == 2'd1);
   assign addr_unused = ^{req_addr[35:34], req_addr[6], req_addr[1:0]};

   assign req_ready = (state == S_IDLE);
   assign busy      = (state != S_IDLE);

`ifdef MSD_OPEN_PAGE_EN
   localparam int unsigned BANKS = 32;
   logic [BANKS-1:0]  tbl_vld;
   logic [15:0]       tbl_row  [BANKS];
   logic [CNT_W-1:0]  bank_ras [BANKS];
   logic              act_pend;
   logic              pre_pend;
   logic [4:0]        req_bank;
   logic [4:0]        cur_bank;

   assign req_bank = {req_bg, req_ba};
   assign cur_bank = {cmd_bg, cmd_ba};
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         cmd_valid <= 1'b0;
         cmd_code  <= CMD_NOP;
         cmd_bg    <= '0;
         cmd_ba    <= '0;
         cmd_row   <= '0;
         cmd_col   <= '0;
         done      <= 1'b0;
         is_wr     <= 1'b0;
         wait_cnt  <= '0;
         ras_cnt   <= '0;
         dat_cnt   <= '0;
         pre_cnt   <= '0;
`ifdef MSD_OPEN_PAGE_EN
         act_pend  <= 1'b0;
         pre_pend  <= 1'b0;
         tbl_vld   <= '0;
         for (int i = 0; i < BANKS; i++) begin
            tbl_row[i]  <= '0;
            bank_ras[i] <= '0;
         end
`endif
      end else begin
         cmd_valid <= 1'b0;
         cmd_code  <= CMD_NOP;
         done      <= (dat_cnt == CNT_W'(1));
         // Free-running down-counters; each is loaded at the event it times from
         if (ras_cnt != '0) ras_cnt <= ras_cnt - CNT_W'(1);
         if (dat_cnt != '0) dat_cnt <= dat_cnt - CNT_W'(1);
         if (pre_cnt != '0) pre_cnt <= pre_cnt - CNT_W'(1);
`ifdef MSD_OPEN_PAGE_EN
         for (int i = 0; i < BANKS; i++) begin
            if (bank_ras[i] != '0) bank_ras[i] <= bank_ras[i] - CNT_W'(1);
         end
`endif
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  is_wr   <= req_wr;
                  cmd_bg  <= req_bg;
                  cmd_ba  <= req_ba;
                  cmd_row <= req_row;
                  cmd_col <= req_col;
`ifdef MSD_OPEN_PAGE_EN
                  if (tbl_vld[req_bank] && (tbl_row[req_bank] == req_row)) begin
                     state     <= S_CAS0;
                     cmd_valid <= 1'b1;
                     cmd_code  <= req_wr ? CMD_WR0 : CMD_RD0;
                  end else if (tbl_vld[req_bank]) begin
                     act_pend <= 1'b1;
                     if (bank_ras[req_bank] <= CNT_W'(1)) begin
                        state             <= S_PRE;
                        cmd_valid         <= 1'b1;
                        cmd_code          <= CMD_PRE;
                        tbl_vld[req_bank] <= 1'b0;
                     end else begin
                        // Hold off the row-miss PRE until this bank's tRAS expires
                        state    <= S_WAIT_RP;
                        wait_cnt <= bank_ras[req_bank] - CNT_W'(1);
                        pre_pend <= 1'b1;
                     end
                  end else begin
                     state              <= S_ACT0;
                     cmd_valid          <= 1'b1;
                     cmd_code           <= CMD_ACT0;
                     ras_cnt            <= CNT_W'(T_RAS);
                     tbl_vld[req_bank]  <= 1'b1;
                     tbl_row[req_bank]  <= req_row;
                     bank_ras[req_bank] <= CNT_W'(T_RAS);
                  end
`else
                  state     <= S_ACT0;
                  cmd_valid <= 1'b1;
                  cmd_code  <= CMD_ACT0;
                  ras_cnt   <= CNT_W'(T_RAS);
`endif
               end
            end
            S_ACT0: begin
               state     <= S_ACT1;
               cmd_valid <= 1'b1;
               cmd_code  <= CMD_ACT1;
            end
            S_ACT1: begin
               state    <= S_WAIT_RCD;
               wait_cnt <= CNT_W'(T_RCD - 2);
            end
            S_WAIT_RCD: begin
               if (wait_cnt <= CNT_W'(1)) begin
                  state     <= S_CAS0;
                  cmd_valid <= 1'b1;
                  cmd_code  <= is_wr ? CMD_WR0 : CMD_RD0;
               end else begin
                  wait_cnt <= wait_cnt - CNT_W'(1);
               end
            end
            S_CAS0: begin
               state     <= S_CAS1;
               cmd_valid <= 1'b1;
               cmd_code  <= is_wr ? CMD_WR1 : CMD_RD1;
               dat_cnt   <= is_wr ? CNT_W'(LAT_WR) : CNT_W'(LAT_RD);
               pre_cnt   <= is_wr ? CNT_W'(LAT_WR + T_WR) : CNT_W'(LAT_RD);
            end
            S_CAS1, S_WAIT_DATA: begin
`ifdef MSD_OPEN_PAGE_EN
               if (pre_cnt <= CNT_W'(1)) state <= S_IDLE;
               else                      state <= S_WAIT_DATA;
`else
               if ((pre_cnt <= CNT_W'(1)) && (ras_cnt <= CNT_W'(1))) begin
                  state     <= S_PRE;
                  cmd_valid <= 1'b1;
                  cmd_code  <= CMD_PRE;
               end else begin
                  state <= S_WAIT_DATA;
               end
`endif
            end
            S_PRE: begin
               state    <= S_WAIT_RP;
               wait_cnt <= CNT_W'(T_RP - 1);
            end
            S_WAIT_RP: begin
               if (wait_cnt <= CNT_W'(1)) begin
`ifdef MSD_OPEN_PAGE_EN
                  if (pre_pend) begin
                     pre_pend          <= 1'b0;
                     state             <= S_PRE;
                     cmd_valid         <= 1'b1;
                     cmd_code          <= CMD_PRE;
                     tbl_vld[cur_bank] <= 1'b0;
                  end else if (act_pend) begin
                     act_pend           <= 1'b0;
                     state              <= S_ACT0;
                     cmd_valid          <= 1'b1;
                     cmd_code           <= CMD_ACT0;
                     ras_cnt            <= CNT_W'(T_RAS);
                     tbl_vld[cur_bank]  <= 1'b1;
                     tbl_row[cur_bank]  <= cmd_row;
                     bank_ras[cur_bank] <= CNT_W'(T_RAS);
                  end else begin
                     state <= S_IDLE;
                  end
`else
                  state <= S_IDLE;
`endif
               end else begin
                  wait_cnt <= wait_cnt - CNT_W'(1);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_msd_dram_cmd_gen.sv
// Randomized bench for msd_dram_cmd_gen: a schedule model derived from the DDR5 timing rules
// predicts every cycle of each request; honours MSD_OPEN_PAGE_EN like the design.
module tb_msd_dram_cmd_gen;
   localparam int T_RCD   = 39;
   localparam int T_CL    = 40;
   localparam int T_CWL   = 38;
   localparam int T_BURST = 8;
   localparam int T_RAS   = 76;
   localparam int T_WR    = 30;
   localparam int T_RP    = 39;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_oper;
   logic [35:0] req_addr;
   logic        cmd_valid;
   logic [2:0]  cmd_code;
   logic [2:0]  cmd_bg;
   logic [1:0]  cmd_ba;
   logic [15:0] cmd_row;
   logic [9:0]  cmd_col;
   logic        done;
   logic        busy;

   int nchecks = 0;
   int nerrs   = 0;
   int now     = 0;

   // Reference open-row table: row, valid flag and absolute cycle when tRAS is met
   bit          tbl_vld    [32];
   logic [15:0] tbl_row    [32];
   int          ras_ok_abs [32];

   msd_dram_cmd_gen dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_oper  (req_oper),
      .req_addr  (req_addr),
      .cmd_valid (cmd_valid),
      .cmd_code  (cmd_code),
      .cmd_bg    (cmd_bg),
      .cmd_ba    (cmd_ba),
      .cmd_row   (cmd_row),
      .cmd_col   (cmd_col),
      .done      (done),
      .busy      (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) now++;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nchecks++;
      if (got !== exp) begin
         nerrs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clear_model();
      for (int i = 0; i < 32; i++) begin
         tbl_vld[i]    = 1'b0;
         tbl_row[i]    = '0;
         ras_ok_abs[i] = 0;
      end
   endtask

   // Called in an IDLE cycle; issues one request and checks every cycle until IDLE again.
   task automatic run_req(input logic [1:0] op, input logic [35:0] addr, input bit hold, input bit noise);
      logic [2:0]  ecode [0:511];
      logic [15:0] row;
      logic [9:0]  col;
      logic [2:0]  bg;
      logic [1:0]  ba;
      int          bk, base, act0, cas0, d, idle_c, pre_c;
      bit          wr;
      wr   = (op == 2'd1);
      row  = addr[33:18];
      col  = {addr[17:12], addr[5:2]};
      ba   = addr[11:10];
      bg   = addr[9:7];
      bk   = {bg, ba};
      base = now;
      for (int i = 0; i < 512; i++) ecode[i] = 3'd0;
`ifdef MSD_OPEN_PAGE_EN
      if (tbl_vld[bk] && tbl_row[bk] == row) begin
         act0 = 0;
         cas0 = 1;
      end else if (tbl_vld[bk]) begin
         pre_c = (ras_ok_abs[bk] - base > 1) ? ras_ok_abs[bk] - base : 1;
         ecode[pre_c] = 3'd7;
         act0 = pre_c + T_RP;
         cas0 = act0 + T_RCD;
      end else begin
         act0 = 1;
         cas0 = 1 + T_RCD;
      end
      d      = cas0 + (wr ? T_CWL : T_CL) + T_BURST;
      idle_c = wr ? d + T_WR : d;
      if (act0 > 0) begin
         tbl_vld[bk]    = 1'b1;
         tbl_row[bk]    = row;
         ras_ok_abs[bk] = base + act0 + T_RAS;
      end
`else
      act0   = 1;
      cas0   = 1 + T_RCD;
      d      = cas0 + (wr ? T_CWL : T_CL) + T_BURST;
      pre_c  = wr ? d + T_WR : d;
      if (act0 + T_RAS > pre_c) pre_c = act0 + T_RAS;
      ecode[pre_c] = 3'd7;
      idle_c = pre_c + T_RP;
`endif
      if (act0 > 0) begin
         ecode[act0]     = 3'd1;
         ecode[act0 + 1] = 3'd2;
      end
      ecode[cas0]     = wr ? 3'd5 : 3'd3;
      ecode[cas0 + 1] = wr ? 3'd6 : 3'd4;

      check_eq("ready_at_accept", req_ready, 1);
      req_valid = 1'b1;
      req_oper  = op;
      req_addr  = addr;
      @(posedge clk); #1;
      for (int c = 1; c <= idle_c; c++) begin
         check_eq($sformatf("code@%0d", c), cmd_code, ecode[c]);
         check_eq($sformatf("valid@%0d", c), cmd_valid, ecode[c] != 3'd0);
         check_eq($sformatf("done@%0d", c), done, c == d);
         check_eq($sformatf("ready@%0d", c), req_ready, c == idle_c);
         check_eq($sformatf("busy@%0d", c), busy, c != idle_c);
         check_eq($sformatf("bg@%0d", c), cmd_bg, bg);
         check_eq($sformatf("ba@%0d", c), cmd_ba, ba);
         check_eq($sformatf("row@%0d", c), cmd_row, row);
         check_eq($sformatf("col@%0d", c), cmd_col, col);
         if (c == idle_c) begin
            if (!hold) req_valid = 1'b0;
         end else if (noise) begin
            req_valid = 1'($urandom);
            req_oper  = 2'($urandom);
            req_addr  = {4'($urandom), 32'($urandom)};
         end
         if (c < idle_c) begin
            @(posedge clk); #1;
         end
      end
   endtask

   initial begin
      logic [35:0] a;
      logic [2:0]  exp_code;
      int          gap;
      clear_model();
      rst       = 1'b1;
      req_valid = 1'b0;
      req_oper  = 2'd0;
      req_addr  = '0;
      #1;
      check_eq("rst_cmd_valid", cmd_valid, 0);
      check_eq("rst_cmd_code", cmd_code, 0);
      check_eq("rst_row", cmd_row, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_ready", req_ready, 1);
      check_eq("rst_busy", busy, 0);
      req_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_ignores_req", cmd_code, 0);
      req_valid = 1'b0;
      rst       = 1'b0;
      @(posedge clk); #1;

      // Reset mid-read: abort at cycle 50, no PRE afterwards
      req_valid = 1'b1;
      req_oper  = 2'd0;
      req_addr  = 36'h0_0004_0680;
      @(posedge clk); #1;
      req_valid = 1'b0;
      for (int c = 1; c <= 50; c++) begin
         exp_code = (c == 1) ? 3'd1 : (c == 2) ? 3'd2 : (c == 1 + T_RCD) ? 3'd3 :
                    (c == 2 + T_RCD) ? 3'd4 : 3'd0;
         check_eq($sformatf("pre_abort_code@%0d", c), cmd_code, exp_code);
         if (c < 50) begin
            @(posedge clk); #1;
         end
      end
      rst       = 1'b1;
      req_valid = 1'b1;
      #1;
      check_eq("abort_code", cmd_code, 0);
      check_eq("abort_valid", cmd_valid, 0);
      check_eq("abort_bg", cmd_bg, 0);
      check_eq("abort_row", cmd_row, 0);
      check_eq("abort_ready", req_ready, 1);
      check_eq("abort_busy", busy, 0);
      @(posedge clk); #1;
      req_valid = 1'b0;
      rst       = 1'b0;
      clear_model();
      for (int c = 0; c < 90; c++) begin
         @(posedge clk); #1;
         check_eq($sformatf("after_abort_code@%0d", c), cmd_code, 0);
         check_eq($sformatf("after_abort_ready@%0d", c), req_ready, 1);
      end

      // Directed sequences: read, write, ifetch, back-to-back reads, row change in one bank
      run_req(2'd0, 36'h0_0004_0680, 1'b0, 1'b0);
      run_req(2'd1, 36'h0_0004_0680, 1'b0, 1'b0);
      run_req(2'd2, 36'h0_0004_0680, 1'b0, 1'b0);
      run_req(2'd0, 36'h0_0004_0680, 1'b1, 1'b0);
      run_req(2'd0, 36'h0_0004_0680, 1'b0, 1'b0);
      run_req(2'd0, 36'h0_0008_0680, 1'b0, 1'b0);
      run_req(2'd3, 36'h0_0008_0680, 1'b0, 1'b1);

      // Random requests, biased toward one bank and two rows to exercise row reuse
      for (int n = 0; n < 12; n++) begin
         a = {4'($urandom), 32'($urandom)};
         if ($urandom_range(0, 1) == 1) begin
            a[11:7]  = 5'b01101;
            a[33:18] = 16'($urandom_range(1, 2));
         end
         run_req(2'($urandom), a, 1'b0, 1'($urandom));
         gap = $urandom_range(0, 3);
         for (int g = 0; g < gap; g++) begin
            @(posedge clk); #1;
            check_eq($sformatf("gap_ready%0d_%0d", n, g), req_ready, 1);
            check_eq($sformatf("gap_code%0d_%0d", n, g), cmd_code, 0);
         end
      end

      $display("Result: errors=%0d of %0d checks", nerrs, nchecks);
      $finish;
   end
endmodule
